// File: rtl/flash_pkg.sv
// Shared state encoding and parameter defaults for the flash burst reader.
package flash_pkg;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam int DEF_DATA_BYTES   = 2;
    localparam int DEF_ADDR_W       = 21;
    localparam int DEF_WAIT_CYCLES  = 4;
    localparam int DEF_RESET_CYCLES = 500;
    localparam int DEF_LEN_W        = 4;

endpackage

// File: rtl/flash_access_timer.sv
// Per-byte access timer: counts 0..WAIT_CYCLES while run is high and strobes on
// the final count so the byte is sampled on the edge that closes the access.
module flash_access_timer
    import flash_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic strobe
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt;

    assign strobe = run && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flash_burst_reader.sv
// Burst reader for a byte-wide parallel NOR flash: fetches req_len+1 words of
// DATA_BYTES bytes each, packed little-endian, after a power-on flash reset hold.
module flash_burst_reader
    import flash_pkg::*;
#(
    parameter int DATA_BYTES   = DEF_DATA_BYTES,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int LEN_W        = DEF_LEN_W
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [ADDR_W-1:0]                       req_addr,
    input  logic [LEN_W-1:0]                        req_len,
    input  logic                                    abort,
    output logic                                    rd_valid,
    output logic [8*DATA_BYTES-1:0]                 rd_data,
    output logic                                    rd_last,
    output logic                                    busy,
    output logic [ADDR_W+$clog2(DATA_BYTES)-1:0]    flash_a,
    input  logic [7:0]                              flash_d,
    output logic                                    flash_we_n,
    output logic                                    flash_reset_n,
    output logic                                    flash_ce_n,
    output logic                                    flash_oe_n
);

    localparam int BI_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(DATA_BYTES - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);

    state_t                  state;
    logic [RST_W-1:0]        rst_cnt;
    logic [ADDR_W-1:0]       word_addr;
    logic [BI_W-1:0]         byte_idx;
    logic [LEN_W-1:0]        remaining;
    logic [8*DATA_BYTES-1:0] word_buf;
    logic [8*DATA_BYTES-1:0] word_next;
    logic                    sample;

    flash_access_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == S_ACCESS),
        .strobe(sample)
    );

    assign req_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign flash_reset_n = (state != S_RESET);
    assign flash_ce_n    = (state != S_ACCESS);
    assign flash_oe_n    = (state != S_ACCESS);
    assign flash_we_n    = 1'b1;

    generate
        if (DATA_BYTES > 1) begin : g_multi
            assign flash_a = {word_addr, byte_idx};
        end else begin : g_single
            logic unused_idx;
            assign unused_idx = ^byte_idx;
            assign flash_a    = word_addr;
        end
    endgenerate

    // Merge the byte on the bus into the partially assembled word.
    always_comb begin
        word_next = word_buf;
        word_next[8*byte_idx +: 8] = flash_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            rst_cnt   <= '0;
            word_addr <= '0;
            byte_idx  <= '0;
            remaining <= '0;
            word_buf  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        word_addr <= req_addr;
                        remaining <= req_len;
                        byte_idx  <= '0;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Abort beats a coincident final-byte sample.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (sample) begin
                        if (byte_idx == LAST_BYTE) begin
                            rd_data   <= word_next;
                            rd_valid  <= 1'b1;
                            byte_idx  <= '0;
                            word_addr <= word_addr + 1'b1;
                            if (remaining == '0) begin
                                rd_last <= 1'b1;
                                state   <= S_IDLE;
                            end else begin
                                remaining <= remaining - 1'b1;
                            end
                        end else begin
                            word_buf <= word_next;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Randomized bench for flash_burst_reader: a default instance and a 4-byte/1-wait
// instance, each read back against a word-level model of address, data and timing.
module tb_flash_burst_reader;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        last;
    } mon_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv0, rv1;
    logic [20:0] req_addr;
    logic [3:0]  req_len;
    logic        abort;

    logic        rdy0, rdv0, last0, busy0, we0, frst0, ce0, oe0;
    logic [15:0] rdata0;
    logic [21:0] fa0;
    logic [7:0]  fd0;

    logic        rdy1, rdv1, last1, busy1, we1, frst1, ce1, oe1;
    logic [31:0] rdata1;
    logic [22:0] fa1;
    logic [7:0]  fd1;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    mon_t q0[$];
    mon_t q1[$];
    mon_t g_got[$];
    int   g_acc, g_end;

    // Flash contents: each location holds the low byte of its own address.
    assign fd0 = fa0[7:0];
    assign fd1 = fa1[7:0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flash_burst_reader dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rdy0),
        .req_addr(req_addr), .req_len(req_len), .abort(abort),
        .rd_valid(rdv0), .rd_data(rdata0), .rd_last(last0), .busy(busy0),
        .flash_a(fa0), .flash_d(fd0), .flash_we_n(we0), .flash_reset_n(frst0),
        .flash_ce_n(ce0), .flash_oe_n(oe0)
    );

    flash_burst_reader #(
        .DATA_BYTES(4), .WAIT_CYCLES(1), .RESET_CYCLES(20)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1),
        .req_addr(req_addr), .req_len(req_len), .abort(abort),
        .rd_valid(rdv1), .rd_data(rdata1), .rd_last(last1), .busy(busy1),
        .flash_a(fa1), .flash_d(fd1), .flash_we_n(we1), .flash_reset_n(frst1),
        .flash_ce_n(ce1), .flash_oe_n(oe1)
    );

    always @(posedge clk) begin : mon0
        mon_t m;
        #1;
        if (rdv0) begin
            m.cyc = cyc; m.data = 32'(rdata0); m.last = last0;
            q0.push_back(m);
        end
    end

    always @(posedge clk) begin : mon1
        mon_t m;
        #1;
        if (rdv1) begin
            m.cyc = cyc; m.data = rdata1; m.last = last1;
            q1.push_back(m);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Word at word address wa: byte b lives at flash address wa*db+b.
    function automatic logic [31:0] model_word(input int db, input int wa);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < db; b++) w[8*b +: 8] = 8'((wa * db + b) & 255);
        return w;
    endfunction

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, rdy0, 0);
        check_eq({tag, "_busy"}, busy0, 1);
        check_eq({tag, "_rdvalid"}, rdv0, 0);
        check_eq({tag, "_rdlast"}, last0, 0);
        check_eq({tag, "_rddata"}, rdata0, 0);
        check_eq({tag, "_flrst"}, frst0, 0);
        check_eq({tag, "_oe"}, oe0, 1);
        check_eq({tag, "_ce"}, ce0, 1);
        check_eq({tag, "_we"}, we0, 1);
        check_eq({tag, "_ready1"}, rdy1, 0);
    endtask

    // Called right after rst_n rises (between edges); counts edges until flash_reset_n rises.
    task automatic count_reset_hold(input string tag);
        int n;
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            abort = (n % 7 == 3);
            if (frst0) break;
        end
        abort = 1'b0;
        check_eq({tag, "_hold"}, n, 500);
        check_eq({tag, "_ready"}, rdy0, 1);
        check_eq({tag, "_busy"}, busy0, 0);
    endtask

    // Caller is between a posedge and the following negedge-or-earlier; returns at a negedge.
    task automatic burst_and_check(input int sel, input logic [20:0] a, input int len, input int j);
        int db, per, n_exp, t, acc, end_exp, wa;
        bit done;
        mon_t got[$];
        db  = sel ? 4 : 2;
        per = sel ? 8 : 10;
        if (sel) q1.delete(); else q0.delete();
        t = 0;
        while (!(sel ? rdy1 : rdy0) && t < 2000) begin @(negedge clk); t++; end
        check_eq("req_ready_wait", t < 2000, 1);
        req_addr = a;
        req_len  = 4'(len);
        if (sel) rv1 = 1'b1; else rv0 = 1'b1;
        @(negedge clk);
        acc = cyc;
        rv0 = 1'b0;
        rv1 = 1'b0;
        t = 0;
        done = 0;
        while (!done) begin
            abort = (j > 0) && (cyc == acc + j - 1);
            if (!(sel ? busy1 : busy0) || t > 4000) done = 1;
            else begin @(negedge clk); t++; end
        end
        abort = 1'b0;
        check_eq("burst_timeout", t <= 4000, 1);

        n_exp   = len + 1;
        end_exp = (len + 1) * per;
        if (j > 0 && j <= (len + 1) * per) begin
            if ((j - 1) / per < n_exp) n_exp = (j - 1) / per;
            end_exp = j;
        end
        got = sel ? q1 : q0;
        check_eq("word_count", got.size(), n_exp);
        for (int k = 0; k < got.size() && k < n_exp; k++) begin
            wa = (int'(a) + k) & 32'h1FFFFF;
            check_eq("word_time", got[k].cyc - acc, (k + 1) * per);
            check_eq("word_data", got[k].data, model_word(db, wa));
            check_eq("word_last", got[k].last, k == len);
        end
        check_eq("end_time", cyc - acc, end_exp);
        check_eq("ready_after", sel ? rdy1 : rdy0, 1);
        g_got = got;
        g_acc = acc;
        g_end = acc + end_exp;
    endtask

    initial begin
        int sel, len, j, per, a1end;
        rst_n = 1'b0; rv0 = 1'b0; rv1 = 1'b0; abort = 1'b0;
        req_addr = '0; req_len = '0;

        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        count_reset_hold("por");
        check_eq("ready1_after_por", rdy1, 1);

        // Single-word burst, first data 10 clocks after accept.
        burst_and_check(0, 21'h000010, 0, 0);
        check_eq("one_word_data", g_got.size() > 0 ? g_got[0].data : 32'hDEAD, 32'h2120);
        check_eq("one_word_lat", g_got.size() > 0 ? g_got[0].cyc - g_acc : -1, 10);

        // Address wrap across the top of the word space.
        burst_and_check(0, 21'h1FFFFE, 3, 0);
        check_eq("wrap_word2", g_got.size() > 2 ? g_got[2].data : 32'hDEAD, 32'h0100);
        a1end = g_end;

        // Back-to-back: accepted on the edge right after the rd_last cycle.
        burst_and_check(0, 21'h0ABCDE, 1, 0);
        check_eq("b2b_accept", g_acc, a1end + 1);

        // Abort 3 clocks into the second word, then abort on a final-byte sample.
        burst_and_check(0, 21'h000200, 7, 13);
        burst_and_check(0, 21'h000300, 7, 20);

        // Four-byte words with one wait state.
        burst_and_check(1, 21'h000041, 3, 0);
        check_eq("wide_data", g_got.size() > 0 ? g_got[0].data : 32'hDEAD, 32'h07060504);

        for (int i = 0; i < 10; i++) begin
            sel = (i % 3 == 2) ? 1 : 0;
            per = sel ? 8 : 10;
            len = $urandom_range(0, 15);
            j   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (len + 1) * per) : 0;
            burst_and_check(sel, 21'($urandom), len, j);
        end

        // Reset in the middle of a burst.
        q0.delete();
        req_addr = 21'h001234; req_len = 4'd7; rv0 = 1'b1;
        @(negedge clk);
        rv0 = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("mid_pre_words", q0.size(), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        count_reset_hold("mid");
        check_eq("mid_no_words", q0.size(), 0);
        burst_and_check(0, 21'h000777, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_burst_reader.md
FLASH_BURST_READER -- requirements
Module: flash_burst_reader

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2: flash bytes per returned word (1, 2 or 4).
REQ-002 SHALL have parameter ADDR_W, default 21: word address width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 4: extra clocks per byte access, so each byte access takes WAIT_CYCLES+1 clocks.
REQ-004 SHALL have parameter RESET_CYCLES, default 500: clocks flash_reset_n is held low after reset release.
REQ-005 SHALL have parameter LEN_W, default 4: burst length field width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; every flop on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_addr (in, ADDR_W), req_len (in, LEN_W): the burst request; length is req_len+1 words.
REQ-009 SHALL have port abort, input, 1 bit: terminates the active burst.
REQ-010 SHALL have ports rd_valid (out, 1), rd_data (out, 8*DATA_BYTES), rd_last (out, 1): returned word stream, no backpressure.
REQ-011 SHALL have port busy, output, 1 bit: high when the block is not idle.
REQ-012 SHALL have ports flash_a (out, ADDR_W+log2(DATA_BYTES)), flash_d (in, 8), flash_we_n, flash_reset_n, flash_ce_n, flash_oe_n (out, 1 each).

Function
REQ-013 SHALL implement states S_RESET, S_IDLE and S_ACCESS.
REQ-014 S_RESET SHALL go to S_IDLE once RESET_CYCLES clocks have elapsed since rst_n rose; flash_reset_n SHALL go high on that same edge.
REQ-015 req_ready SHALL equal (state==S_IDLE).
REQ-016 A request SHALL be accepted on an edge where req_valid&req_ready is high.
REQ-017 On acceptance the block SHALL latch the address and remaining count and enter S_ACCESS, starting at byte 0.
REQ-018 flash_a SHALL equal {word_addr, byte_idx} from the cycle after acceptance.
REQ-019 flash_oe_n and flash_ce_n SHALL be low only in S_ACCESS; flash_we_n SHALL be tied high.
REQ-020 With E0 the accept edge, byte b SHALL be sampled from flash_d at edge E0+(b+1)*(WAIT_CYCLES+1).
REQ-021 Bytes SHALL be packed little-endian: byte 0 goes to rd_data[7:0].
REQ-022 rd_valid SHALL pulse one cycle, registered on the edge sampling the final byte; with defaults, the first word appears 10 clocks after accept.
REQ-023 rd_data SHALL hold its value until the next word.
REQ-024 The next word's access SHALL start on the same edge as rd_valid, giving a word period of DATA_BYTES*(WAIT_CYCLES+1) clocks with no idle gap.
REQ-025 The word address SHALL increment by 1 per word modulo 2^ADDR_W, so 0x1FFFFF is followed by 0x000000.
REQ-026 rd_last SHALL accompany rd_valid for the final word only; on that edge the state SHALL return to S_IDLE, so req_ready is high in the rd_last cycle.
REQ-027 A back-to-back request accepted in the rd_last cycle SHALL be accepted on the following edge.
REQ-028 req_len=0 SHALL produce exactly one word with rd_last set.
REQ-029 abort high in S_ACCESS SHALL force S_IDLE on the next edge, discard the partial word and suppress rd_valid.
REQ-030 If abort coincides with the final-byte sample, abort SHALL win and no rd_valid is produced.
REQ-031 abort SHALL be ignored in S_IDLE and S_RESET.
REQ-032 busy SHALL equal (state!=S_IDLE).

Reset
REQ-033 rst_n low SHALL immediately force state=S_RESET, req_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=1, flash_reset_n=0, flash_oe_n=1, flash_ce_n=1, and clear the reset timer.
REQ-034 Reset asserted mid-burst SHALL drop the burst with no rd_valid and SHALL restart the full RESET_CYCLES hold.

Structure
REQ-035 The state enum and parameter defaults SHALL live in package flash_pkg.
REQ-036 Per-byte wait counting SHALL be a sub-module, flash_access_timer, which counts 0..WAIT_CYCLES and pulses a sample strobe.

Verification
REQ-037 Bench SHALL check: after rst_n release with defaults, flash_reset_n is 0 for 500 clocks, then req_ready=1.
REQ-038 Bench SHALL check: defaults, flash model data=address low byte, req addr 0x000010 len 0 -> one rd_valid 10 clocks after accept with rd_data=0x2120, rd_last=1.
REQ-039 Bench SHALL check: addr 0x1FFFFE len 3 -> four words at 10-clock spacing, word addresses 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001, rd_last on the 4th only.
REQ-040 Bench SHALL check: abort asserted 3 clocks into the 2nd word of a len 7 burst -> exactly 1 rd_valid, req_ready=1 the next cycle.
REQ-041 Bench SHALL check: DATA_BYTES=4, WAIT_CYCLES=1 -> word period 8 clocks, little-endian 32-bit packing.
REQ-042 Bench SHALL check: rst_n pulsed low mid-burst -> outputs go to reset values asynchronously and no further rd_valid occurs.
